// File: rtl/hpdcache_wrrarb_pkg.sv
// Shared helpers for the weighted round-robin arbiter and its one-hot utilities.
package hpdcache_wrrarb_pkg;

   // Index width for an N-entry one-hot vector, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hpdcache_1hot_to_binary.sv
// One-hot to binary index converter; an all-zero input yields index 0.
module hpdcache_1hot_to_binary
   import hpdcache_wrrarb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] val_i,
   output logic [W-1:0] val_o
);

   always_comb begin
      val_o = '0;
      for (int i = 0; i < N; i++) begin
         if (val_i[i]) val_o = val_o | W'(i);
      end
   end

endmodule

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Fixed-priority selector: keeps only the lowest set bit of the input vector.
module hpdcache_prio_1hot_encoder #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] val_i,
   output logic [N-1:0] val_o
);

   logic w_found;

   always_comb begin
      val_o   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (val_i[i] && !w_found) begin
            val_o[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hpdcache_wrrarb.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to weff(owner)
// accepted transfers; a presented grant is held until ready_i.
//    wait_q | meaning
//    0      | grant computed combinationally from req_i this cycle
//    1      | grant presented without ready, replaying gnt_q
module hpdcache_wrrarb
   import hpdcache_wrrarb_pkg::*;
#(
   parameter  int unsigned N    = 4,
   parameter  int unsigned WW   = 4,
   localparam int unsigned IDXW = idx_width(N)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [N-1:0]      req_i,
   input  logic [N*WW-1:0]   weight_i,
   input  logic              ready_i,
   output logic [N-1:0]      gnt_o,
   output logic [IDXW-1:0]   gnt_idx_o,
   output logic [IDXW-1:0]   owner_o
);

   if (N < 1) begin : g_bad_n
      $error("hpdcache_wrrarb: N must be at least 1");
   end

   localparam logic [N-1:0] GNT_RST = N'(1) << (N - 1);

   logic [N-1:0]    r_gnt_q;
   logic            r_wait_q;
   logic [WW-1:0]   r_cnt_q;

   logic            w_pending;
   logic            w_retain;
   logic [IDXW-1:0] w_owner_idx;
   logic [WW-1:0]   w_owner_w;
   logic [WW-1:0]   w_owner_weff;
   logic [WW-1:0]   w_cnt_inc;
   logic [N-1:0]    w_rotl;
   logic [N-1:0]    w_mask;
   logic [N-1:0]    w_masked_req;
   logic [N-1:0]    w_gnt_masked;
   logic [N-1:0]    w_gnt_unmasked;
   logic [N-1:0]    w_gnt;

   assign w_pending = |req_i;

   if (N == 1) begin : g_rot_single
      assign w_rotl = r_gnt_q;
   end else begin : g_rot_multi
      assign w_rotl = {r_gnt_q[N-2:0], r_gnt_q[N-1]};
   end

   // Thermometer from the bit after the owner upward: requesters above the owner.
   always_comb begin
      w_mask    = '0;
      w_mask[0] = w_rotl[0];
      for (int i = 1; i < N; i++) begin
         w_mask[i] = w_mask[i-1] | w_rotl[i];
      end
   end

   assign w_masked_req = req_i & w_mask;

   hpdcache_prio_1hot_encoder #(.N(N)) u_prio_masked (
      .val_i (w_masked_req),
      .val_o (w_gnt_masked)
   );

   hpdcache_prio_1hot_encoder #(.N(N)) u_prio_unmasked (
      .val_i (req_i),
      .val_o (w_gnt_unmasked)
   );

   hpdcache_1hot_to_binary #(.N(N), .W(IDXW)) u_owner_idx (
      .val_i (r_gnt_q),
      .val_o (w_owner_idx)
   );

   hpdcache_1hot_to_binary #(.N(N), .W(IDXW)) u_gnt_idx (
      .val_i (gnt_o),
      .val_o (gnt_idx_o)
   );

   always_comb begin
      w_owner_w = '0;
      for (int i = 0; i < N; i++) begin
         if (w_owner_idx == IDXW'(i)) w_owner_w = weight_i[i*WW +: WW];
      end
   end

   assign w_owner_weff = (w_owner_w == '0) ? WW'(1) : w_owner_w;
   assign w_retain     = (|(req_i & r_gnt_q)) && (r_cnt_q < w_owner_weff);
   assign w_gnt        = w_retain          ? r_gnt_q      :
                         (|w_masked_req)   ? w_gnt_masked : w_gnt_unmasked;
   assign gnt_o        = r_wait_q ? r_gnt_q : w_gnt;
   assign owner_o      = w_owner_idx;
   assign w_cnt_inc    = (r_cnt_q == '1) ? r_cnt_q : r_cnt_q + WW'(1);

   // A round-robin win restarts the quota even if the same requester wins again.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_gnt_q  <= GNT_RST;
         r_wait_q <= 1'b0;
         r_cnt_q  <= '1;
      end else begin
         r_wait_q <= ~ready_i & (r_wait_q | w_pending);
         if (!r_wait_q && w_pending) begin
            r_gnt_q <= w_gnt;
            if (!w_retain) begin
               r_cnt_q <= ready_i ? WW'(1) : '0;
            end else if (ready_i) begin
               r_cnt_q <= w_cnt_inc;
            end
         end else if (r_wait_q && ready_i) begin
            r_cnt_q <= w_cnt_inc;
         end
      end
   end

`ifndef SYNTHESIS
   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o));
   a_gntq_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot(r_gnt_q));
   a_gnt_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_wait_q |-> (gnt_o == $past(gnt_o)));
   a_gnt_idx : assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((gnt_o == '0) && (gnt_idx_o == '0)) || ((gnt_o != '0) && gnt_o[gnt_idx_o]));
`endif

endmodule

// File: tb/tb_hpdcache_wrrarb.sv
// Bench for hpdcache_wrrarb: directed vector table, hand-written corner sequences
// and random traffic, all checked against a queue-free owner/quota reference model.
module tb_hpdcache_wrrarb;

   logic        clk;
   logic        rst_ni;
   logic [3:0]  req_i;
   logic [15:0] weight_i;
   logic        ready_i;
   logic [3:0]  gnt_o;
   logic [1:0]  gnt_idx_o;
   logic [1:0]  owner_o;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner;
   int m_cnt;
   bit m_wait;

   typedef struct {
      bit          rst;
      logic [3:0]  req;
      logic [15:0] w;
      logic        rdy;
      logic [3:0]  exp;
   } vec_t;

   vec_t tbl[$];

   hpdcache_wrrarb #(.N(4), .WW(4)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .weight_i  (weight_i),
      .ready_i   (ready_i),
      .gnt_o     (gnt_o),
      .gnt_idx_o (gnt_idx_o),
      .owner_o   (owner_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int weff(input logic [15:0] w, input int i);
      int v;
      v = int'((w >> (i * 4)) & 16'hF);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < 15) ? v + 1 : 15;
   endfunction

   task automatic model_reset();
      m_owner = 3;
      m_cnt   = 15;
      m_wait  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_ni  = 1'b0;
      req_i   = 4'b0000;
      ready_i = 1'b0;
      #1;
      chk("rst_gnt", gnt_o, 4'b0000);
      chk("rst_idx", gnt_idx_o, 2'd0);
      chk("rst_owner", owner_o, 2'd3);
      chk("rst_cnt", dut.r_cnt_q, 15);
      #1;
      rst_ni = 1'b1;
      model_reset();
   endtask

   // One arbitration cycle: drive at negedge, compare to model, advance model.
   task automatic cycle(input logic [3:0] req, input logic [15:0] w, input logic rdy);
      bit         has;
      bit         retained;
      bit         found;
      int         win;
      logic [3:0] exp_gnt;
      @(negedge clk);
      req_i    = req;
      weight_i = w;
      ready_i  = rdy;
      #1;
      has = 1'b0; retained = 1'b0; found = 1'b0; win = 0;
      if (m_wait) begin
         has = 1'b1;
         win = m_owner;
      end else if (req != 4'b0000) begin
         has = 1'b1;
         if (req[m_owner] && (m_cnt < weff(w, m_owner))) begin
            retained = 1'b1;
            win      = m_owner;
         end else begin
            for (int k = 1; k <= 4; k++) begin
               if (!found && req[(m_owner + k) % 4]) begin
                  found = 1'b1;
                  win   = (m_owner + k) % 4;
               end
            end
         end
      end
      exp_gnt = 4'b0000;
      if (has) exp_gnt[win] = 1'b1;
      chk("gnt_o", gnt_o, exp_gnt);
      chk("gnt_idx_o", gnt_idx_o, has ? win : 0);
      chk("owner_o", owner_o, m_owner);
      chk("cnt_q", dut.r_cnt_q, m_cnt);
      if (m_wait) begin
         if (rdy) begin
            m_cnt  = sat_inc(m_cnt);
            m_wait = 1'b0;
         end
      end else if (has) begin
         if (retained) begin
            if (rdy) m_cnt = sat_inc(m_cnt);
         end else begin
            m_cnt = rdy ? 1 : 0;
         end
         m_owner = win;
         m_wait  = !rdy;
      end
   endtask

   initial begin
      rst_ni   = 1'b1;
      req_i    = 4'b0000;
      weight_i = 16'h1111;
      ready_i  = 1'b0;
      model_reset();
      #1 rst_ni = 1'b0;

      // all weights 1: plain round-robin order 0,1,2,3,0
      tbl.push_back('{1'b1, 4'b1111, 16'h1111, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h1111, 1'b1, 4'b0010});
      tbl.push_back('{1'b0, 4'b1111, 16'h1111, 1'b1, 4'b0100});
      tbl.push_back('{1'b0, 4'b1111, 16'h1111, 1'b1, 4'b1000});
      tbl.push_back('{1'b0, 4'b1111, 16'h1111, 1'b1, 4'b0001});
      // weights w0=3 w1=1 w2=2 w3=0: 0,0,0,1,2,2,3,0,0,0
      tbl.push_back('{1'b1, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0010});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0100});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0100});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b1000});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 16'h0213, 1'b1, 4'b0001});
      // owner drop: w0=4, req0 served once then drops; returns only after 3
      tbl.push_back('{1'b1, 4'b0001, 16'h1114, 1'b1, 4'b0001});
      tbl.push_back('{1'b0, 4'b0100, 16'h1114, 1'b1, 4'b0100});
      tbl.push_back('{1'b0, 4'b1101, 16'h1114, 1'b1, 4'b1000});
      tbl.push_back('{1'b0, 4'b0101, 16'h1114, 1'b1, 4'b0001});

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         cycle(tbl[i].req, tbl[i].w, tbl[i].rdy);
         chk($sformatf("tbl[%0d]_gnt", i), gnt_o, tbl[i].exp);
      end

      // backpressure: grant to 0 held while req0 toggles and ready stays low
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle((k % 2 == 1) ? 4'b0010 : 4'b0011, 16'h2222, 1'b0);
         chk("bp_hold", gnt_o, 4'b0001);
      end
      cycle(4'b0011, 16'h2222, 1'b1);
      chk("bp_accept", gnt_o, 4'b0001);
      @(posedge clk); #1;
      chk("bp_cnt1", dut.r_cnt_q, 1);
      cycle(4'b0011, 16'h2222, 1'b1);
      chk("bp_second", gnt_o, 4'b0001);
      cycle(4'b0011, 16'h2222, 1'b1);
      chk("bp_rotate", gnt_o, 4'b0010);

      // single requester with quota 2: count restarts via the round-robin path
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle(4'b1000, 16'h2111, 1'b1);
         chk("single_gnt", gnt_o, 4'b1000);
         @(posedge clk); #1;
         chk("single_cnt", dut.r_cnt_q, (k % 2) + 1);
      end

      // asynchronous reset while holding a grant for requester 2
      do_reset();
      cycle(4'b0100, 16'h1111, 1'b0);
      chk("midwait_gnt", gnt_o, 4'b0100);
      cycle(4'b0000, 16'h1111, 1'b0);
      chk("midwait_hold", gnt_o, 4'b0100);
      chk("midwait_owner", owner_o, 2'd2);
      do_reset();
      cycle(4'b1111, 16'h1111, 1'b1);
      chk("post_rst_idx", gnt_idx_o, 2'd0);

      // random traffic against the model
      do_reset();
      for (int k = 0; k < 600; k++) begin
         cycle(4'($urandom_range(0, 15)), 16'($urandom),
               ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
